// File: rtl/distance_gray_tracker_pkg.sv
// distance_gray_pkg: shared tracker state type, default widths and Gray helper
package distance_gray_pkg;
  typedef enum logic [0:0] {EMPTY = 1'b0, TRACK = 1'b1} state_e;
  localparam int DIST_W_DEF = 5;
  localparam int GRAY_W_DEF = 3;
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/distance_gray_tracker_if.sv
// distance_gray_tracker_if: sample input and committed Gray output bundle
interface distance_gray_tracker_if #(
  parameter int DIST_W = 5,
  parameter int GRAY_W = 3
);
  logic              in_valid;
  logic [DIST_W-1:0] distance;
  logic [GRAY_W-1:0] gray_code;
  logic              gray_valid;
  logic              changed;
  logic              out_of_range;
  modport master (output in_valid, distance, input gray_code, gray_valid, changed, out_of_range);
  modport slave  (input in_valid, distance, output gray_code, gray_valid, changed, out_of_range);
endinterface

// File: rtl/distance_gray_tracker_binner.sv
// distance_binner: clamps a distance to MAX_DIST and maps it to its bin by shifting
module distance_binner #(
  parameter int DIST_W   = 5,
  parameter int GRAY_W   = 3,
  parameter int MAX_DIST = 30
) (
  input  logic [DIST_W-1:0] distance_i,
  output logic [GRAY_W-1:0] bin_o,
  output logic              oor_o
);
  logic [DIST_W-1:0] d_c;
  always_comb begin
    oor_o = distance_i > DIST_W'(MAX_DIST);
    d_c   = oor_o ? DIST_W'(MAX_DIST) : distance_i;
    bin_o = GRAY_W'(d_c >> (DIST_W - GRAY_W));
  end
endmodule

// File: rtl/distance_gray_tracker.sv
// distance_gray_tracker: bins distance samples, debounces the bin, emits it as Gray code
module distance_gray_tracker
  import distance_gray_pkg::*;
#(
  parameter int DIST_W     = DIST_W_DEF,
  parameter int GRAY_W     = GRAY_W_DEF,
  parameter int MAX_DIST   = 30,
  parameter int STABLE_CNT = 4
) (
  input logic clk,
  input logic rst,
  distance_gray_tracker_if.slave bus
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  logic [GRAY_W-1:0] bin, cand_q, cand_d, comm_q, comm_d, gray_q, gray_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  state_e            state_q, state_d;
  logic              oor, commit, changed_q, oor_q;
  distance_binner #(
    .DIST_W  (DIST_W),
    .GRAY_W  (GRAY_W),
    .MAX_DIST(MAX_DIST)
  ) u_binner (
    .distance_i(bus.distance),
    .bin_o     (bin),
    .oor_o     (oor)
  );
  // commit is judged on the updated run length so it lands one clock after the final sample
  always_comb begin
    cand_d  = bus.in_valid ? bin : cand_q;
    cnt_d   = !bus.in_valid            ? cnt_q :
              (bin != cand_q)          ? CW'(1) :
              (cnt_q == CW'(STABLE_CNT)) ? cnt_q : cnt_q + CW'(1);
    commit  = bus.in_valid && (cnt_d == CW'(STABLE_CNT)) && ((cand_d != comm_q) || (state_q == EMPTY));
    state_d = commit ? TRACK : state_q;
    comm_d  = commit ? cand_d : comm_q;
    gray_d  = commit ? GRAY_W'(bin2gray(16'(cand_d))) : gray_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      comm_q    <= '0;
      gray_q    <= '0;
      state_q   <= EMPTY;
      changed_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      comm_q    <= comm_d;
      gray_q    <= gray_d;
      state_q   <= state_d;
      changed_q <= commit;
      oor_q     <= bus.in_valid && oor;
    end
  end
  assign bus.gray_code    = gray_q;
  assign bus.gray_valid   = (state_q == TRACK);
  assign bus.changed      = changed_q;
  assign bus.out_of_range = oor_q;
endmodule

// File: tb/tb_distance_gray_tracker.sv
// tb_distance_gray_tracker: directed and random checks of two tracker configurations
module tb_distance_gray_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;

  distance_gray_tracker_if #(.DIST_W(5), .GRAY_W(3)) ifa ();
  distance_gray_tracker_if #(.DIST_W(5), .GRAY_W(2)) ifb ();

  distance_gray_tracker #(.DIST_W(5), .GRAY_W(3), .MAX_DIST(30), .STABLE_CNT(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  distance_gray_tracker #(.DIST_W(5), .GRAY_W(2), .MAX_DIST(30), .STABLE_CNT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  // reference: history of valid-sample bins since reset, committed bin per configuration
  int need [2] = '{4, 1};
  int div  [2] = '{4, 8};
  int hist [2][4];
  int nval [2];
  int m_bin[2];
  bit m_vld[2];
  bit m_chg[2];
  bit m_oor[2];

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      nval[k] = 0; m_bin[k] = 0; m_vld[k] = 0; m_chg[k] = 0; m_oor[k] = 0;
      for (int i = 0; i < 4; i++) hist[k][i] = -1;
    end
  endtask

  task automatic model_step(input bit v, input int d);
    for (int k = 0; k < 2; k++) begin
      int b;
      bit same;
      m_chg[k] = 0;
      m_oor[k] = 0;
      if (v) begin
        b = ((d > 30) ? 30 : d) / div[k];
        for (int i = 3; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = b;
        nval[k]++;
        same = 1;
        for (int i = 0; i < need[k]; i++) if (hist[k][i] != b) same = 0;
        if (nval[k] >= need[k] && same && (!m_vld[k] || b != m_bin[k])) begin
          m_chg[k] = 1;
          m_bin[k] = b;
          m_vld[k] = 1;
        end
        m_oor[k] = (d > 30);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a.gray"}, 32'(ifa.gray_code),    32'(to_gray(m_bin[0])));
    chk({tag, ".a.vld"},  32'(ifa.gray_valid),   32'(m_vld[0]));
    chk({tag, ".a.chg"},  32'(ifa.changed),      32'(m_chg[0]));
    chk({tag, ".a.oor"},  32'(ifa.out_of_range), 32'(m_oor[0]));
    chk({tag, ".b.gray"}, 32'(ifb.gray_code),    32'(to_gray(m_bin[1])));
    chk({tag, ".b.vld"},  32'(ifb.gray_valid),   32'(m_vld[1]));
    chk({tag, ".b.chg"},  32'(ifb.changed),      32'(m_chg[1]));
    chk({tag, ".b.oor"},  32'(ifb.out_of_range), 32'(m_oor[1]));
  endtask

  task automatic step(input string tag, input bit v, input int d);
    @(negedge clk);
    ifa.in_valid = v; ifb.in_valid = v;
    ifa.distance = 5'(d); ifb.distance = 5'(d);
    @(posedge clk);
    #1;
    model_step(v, d);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    @(negedge clk);
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  int d;
  int prev_d;
  bit v;

  initial begin
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    ifa.distance = '0;   ifb.distance = '0;
    model_reset();
    do_reset("t1_rst", 3);
    repeat (3) step("t1_idle", 1'b0, 0);
    repeat (4) step("t2", 1'b1, 13);
    chk("t2_gray_const", 32'(ifa.gray_code), 32'b010);
    chk("t2_chg_const",  32'(ifa.changed),   32'd1);
    step("t2_hold", 1'b0, 0);
    chk("t2_chg_drop", 32'(ifa.changed), 32'd0);
    step("t3", 1'b1, 17); step("t3", 1'b1, 17); step("t3", 1'b1, 13);
    repeat (3) step("t3", 1'b1, 17);
    chk("t3_nochange", 32'(ifa.gray_code), 32'b010);
    step("t3", 1'b1, 17);
    chk("t3_gray_const", 32'(ifa.gray_code), 32'b110);
    step("t3_sat", 1'b1, 17);
    chk("t3_sat_chg", 32'(ifa.changed), 32'd0);
    repeat (4) step("t4", 1'b1, 31);
    chk("t4_gray_const", 32'(ifa.gray_code),    32'b100);
    chk("t4_oor_const",  32'(ifa.out_of_range), 32'd1);
    step("t5", 1'b1, 21);
    repeat (5) step("t5_idle", 1'b0, 21);
    repeat (3) step("t5", 1'b1, 21);
    chk("t5_gray_const", 32'(ifa.gray_code), 32'b111);
    repeat (3) step("t6", 1'b1, 25);
    do_reset("t6_rst", 1);
    repeat (3) step("t6_post", 1'b1, 25);
    chk("t6_not_yet", 32'(ifa.gray_valid), 32'd0);
    step("t6_post", 1'b1, 25);
    chk("t6_gray_const", 32'(ifa.gray_code), 32'b101);
    do_reset("t7_rst", 1);
    step("t7", 1'b1, 16);
    chk("t7_b_gray_const", 32'(ifb.gray_code), 32'b11);
    prev_d = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst", 1 + $urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : prev_d;
      prev_d = d;
      step("rnd", v, d);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
